// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the DSP filter chain.
//   FXP_WIDTH / FXP_FRAC : default sample width and fractional bits (Q1.7)
//   sample_t             : default-width signed sample type
//   sat_fit()            : reduce a WIDTH+1-bit sum to WIDTH bits, clamping
//                          or wrapping on overflow
package fxp_pkg;

    localparam int FXP_WIDTH = 8;
    localparam int FXP_FRAC  = 7;

    typedef logic signed [FXP_WIDTH-1:0] sample_t;

    // Overflow shows up as the two top bits of the extended sum disagreeing;
    // the extra top bit then gives the true sign, which picks the clamp rail.
    function automatic sample_t sat_fit(input logic signed [FXP_WIDTH:0] sum,
                                        input logic saturate);
        sample_t result;
        result = sum[FXP_WIDTH-1:0];
        if (saturate && (sum[FXP_WIDTH] != sum[FXP_WIDTH-1])) begin
            result = sum[FXP_WIDTH] ? {1'b1, {(FXP_WIDTH-1){1'b0}}}
                                    : {1'b0, {(FXP_WIDTH-1){1'b1}}};
        end
        return result;
    endfunction

endpackage

// File: rtl/fxp_sat_add.sv
// Combinational signed adder with optional saturation.
//   a, b : WIDTH-bit two's complement operands (same Q format)
//   y    : WIDTH-bit result; clamped to max/min when SATURATE=1,
//          modulo 2^WIDTH when SATURATE=0
module fxp_sat_add #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);

    generate
        if (SATURATE) begin : g_sat
            // One guard bit holds any sum of two WIDTH-bit operands exactly.
            logic signed [WIDTH:0] full;
            logic                  overflow;

            assign full     = {a[WIDTH-1], a} + {b[WIDTH-1], b};
            assign overflow = full[WIDTH] ^ full[WIDTH-1];

            always_comb begin
                y = full[WIDTH-1:0];
                if (overflow) begin
                    y = full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
        end else begin : g_wrap
            // Dropping the carry is exactly modulo 2^WIDTH arithmetic.
            assign y = a + b;
        end
    endgenerate

endmodule

// File: rtl/modport_adder.sv
// Two-tap FIR section (h = [1, 1]): data_out <= fit(data_in + previous data_in).
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset, clears history and output
//   data_in  : signed sample, taken every rising edge
//   data_out : registered sum, 1 clock latency, same Q format as the input
// FRAC is informational only: both taps share the format, so no shift or rounding.
module modport_adder
    import fxp_pkg::*;
#(
    parameter int WIDTH    = FXP_WIDTH,
    parameter int FRAC     = FXP_FRAC,
    parameter bit SATURATE = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic signed [WIDTH-1:0] data_in,
    output logic signed [WIDTH-1:0] data_out
);

    generate
        if (FRAC >= WIDTH) begin : g_frac_check
            $error("FRAC must leave at least the sign bit as an integer bit");
        end
    endgenerate

    logic signed [WIDTH-1:0] x_d;
    logic signed [WIDTH-1:0] sum;

    fxp_sat_add #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_add (
        .a (data_in),
        .b (x_d),
        .y (sum)
    );

    // Clearing x_d on reset makes the first sample after release pass straight
    // through and guarantees no pre-reset history leaks into the output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_d      <= '0;
            data_out <= '0;
        end else begin
            x_d      <= data_in;
            data_out <= sum;
        end
    end

endmodule

// File: tb/tb_modport_adder.sv
// Bench for modport_adder: one saturating and one wrapping instance share the
// same stimulus; expected outputs are queued when a sample is driven and
// popped when the registered result appears one clock later.
module tb_modport_adder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data_in;
    logic [7:0] out_sat;
    logic [7:0] out_wrap;

    int checks = 0;
    int errors = 0;

    logic [7:0] prev;
    logic [7:0] exp_sat_q[$];
    logic [7:0] exp_wrap_q[$];

    always #5 clk = ~clk;

    modport_adder #(.WIDTH(8), .FRAC(7), .SATURATE(1'b1)) dut_sat (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .data_out (out_sat)
    );

    modport_adder #(.WIDTH(8), .FRAC(7), .SATURATE(1'b0)) dut_wrap (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .data_out (out_wrap)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%02h expected=0x%02h", tag, got, exp);
        end else begin
            $display("ok   %s got=0x%02h", tag, got);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input bit sat);
        int          s;
        logic [31:0] bits;
        s = int'($signed(a)) + int'($signed(b));
        if (sat && s > 127)  return 8'h7F;
        if (sat && s < -128) return 8'h80;
        bits = s;
        return bits[7:0];
    endfunction

    // Called at posedge+1: drive one sample, queue its expectation, then
    // check the result one edge later.
    task automatic step(input logic [7:0] x, input string tag);
        logic [7:0] es;
        logic [7:0] ew;
        data_in = x;
        exp_sat_q.push_back(model(x, prev, 1'b1));
        exp_wrap_q.push_back(model(x, prev, 1'b0));
        prev = x;
        @(posedge clk);
        #1;
        if (exp_sat_q.size() == 0 || exp_wrap_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            es = exp_sat_q.pop_front();
            ew = exp_wrap_q.pop_front();
            check({tag, "_sat"}, out_sat, es);
            check({tag, "_wrap"}, out_wrap, ew);
        end
    endtask

    // Assert reset between edges, confirm it acts immediately and holds,
    // then release at posedge+1 so the next edge takes the first sample.
    task automatic pulse_reset(input string tag);
        #3;
        data_in = 8'h55;
        reset_n = 1'b0;
        prev    = 8'h00;
        #1;
        check({tag, "_rst_now_sat"}, out_sat, 8'h00);
        check({tag, "_rst_now_wrap"}, out_wrap, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_rst_hold_sat"}, out_sat, 8'h00);
        check({tag, "_rst_hold_wrap"}, out_wrap, 8'h00);
        reset_n = 1'b1;
    endtask

    typedef logic [7:0] seq_t[];

    task automatic run_seq(input seq_t s, input string tag);
        for (int i = 0; i < s.size(); i++) begin
            step(s[i], $sformatf("%s[%0d]", tag, i));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        data_in = 8'h55;
        prev    = 8'h00;
        #1;
        check("init_rst_sat", out_sat, 8'h00);
        check("init_rst_wrap", out_wrap, 8'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        run_seq('{8'h10, 8'h20, 8'h05}, "basic");
        @(posedge clk); #1;
        pulse_reset("g1");
        run_seq('{8'h70, 8'h70}, "pos_ovf");
        @(posedge clk); #1;
        pulse_reset("g2");
        run_seq('{8'h80, 8'h80}, "neg_ovf");
        @(posedge clk); #1;
        pulse_reset("g3");
        run_seq('{8'h90, 8'hA0}, "neg_ovf2");
        @(posedge clk); #1;
        pulse_reset("g4");
        run_seq('{8'hFF, 8'h01}, "signed_mix");

        // Mid-stream reset: history before reset must not reach the output.
        run_seq('{8'h40, 8'h40}, "pre_mid");
        @(posedge clk); #1;
        pulse_reset("mid");
        run_seq('{8'h30}, "post_mid");
        checks++;
        if (out_sat !== 8'h30) begin
            errors++;
            $display("FAIL mid_history got=0x%02h expected=0x30", out_sat);
        end

        // Random stream, boundaries included by range.
        for (int i = 0; i < 40; i++) begin
            step(8'($urandom_range(0, 255)), $sformatf("rand[%0d]", i));
        end

        checks++;
        if (exp_sat_q.size() != 0 || exp_wrap_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_sat_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
